// File: rtl/parser_input_arbiter.sv
// Packet-level round-robin arbiter feeding the parser input stream, holding each grant for a whole packet.
// One idle arbitration cycle per packet, then a combinational data path; parser ready goes straight back to the granted source only.
module parser_input_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SRC*DATA_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]          src_val,
  input  logic [NUM_SRC-1:0]          src_last,
  output logic [NUM_SRC-1:0]          src_ready,
  output logic [DATA_W-1:0]           dataIn,
  output logic                        dataIn_val,
  output logic                        dataIn_last,
  input  logic                        dataIn_ready,
  input  logic                        packetLost,
  output logic [$clog2(NUM_SRC)-1:0]  grant_id,
  output logic                        grant_active,
  output logic                        timeout_evt,
  output logic [NUM_SRC*CNT_W-1:0]    lost_cnt
);

  localparam int ID_W   = $clog2(NUM_SRC);
  localparam int IDLE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {IDLE, BURST, FLUSH} state_t;

  state_t            state, stateNxt;
  logic [ID_W-1:0]   rrPtr, rrPtrNxt;
  logic [ID_W-1:0]   grantId, grantIdNxt;
  logic [ID_W-1:0]   closedId, closedIdNxt;
  logic [ID_W-1:0]   pickId, nextId, rrIdx;
  logic [ID_W:0]     rrSum;
  logic [IDLE_W-1:0] idleCnt, idleCntNxt;
  logic              timeoutEvt, timeoutEvtNxt, anyReq;
  logic [DATA_W-1:0] srcWord [NUM_SRC];
  logic [CNT_W-1:0]  lostCnt [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign srcWord[i]                  = src_data[i*DATA_W +: DATA_W];
    assign lost_cnt[i*CNT_W +: CNT_W]  = lostCnt[i];
  end

  // Walk from the highest offset down so the requester closest to rrPtr wins.
  always_comb begin
    pickId = rrPtr;
    anyReq = 1'b0;
    rrSum  = '0;
    rrIdx  = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      rrSum = {1'b0, rrPtr} + (ID_W+1)'(k);
      if (rrSum >= (ID_W+1)'(NUM_SRC)) rrSum = rrSum - (ID_W+1)'(NUM_SRC);
      rrIdx = rrSum[ID_W-1:0];
      if (src_val[rrIdx]) begin
        pickId = rrIdx;
        anyReq = 1'b1;
      end
    end
  end

  assign nextId = (grantId == LAST_ID) ? '0 : grantId + 1'b1;

  always_comb begin
    stateNxt      = state;
    grantIdNxt    = grantId;
    rrPtrNxt      = rrPtr;
    closedIdNxt   = closedId;
    idleCntNxt    = idleCnt;
    timeoutEvtNxt = 1'b0;
    src_ready     = '0;
    dataIn        = '0;
    dataIn_val    = 1'b0;
    dataIn_last   = 1'b0;
    case (state)
      IDLE: begin
        if (anyReq) begin
          grantIdNxt = pickId;
          idleCntNxt = '0;
          stateNxt   = BURST;
        end
      end
      BURST: begin
        dataIn             = srcWord[grantId];
        dataIn_val         = src_val[grantId];
        dataIn_last        = src_last[grantId];
        src_ready[grantId] = dataIn_ready;
        if (src_val[grantId] && dataIn_ready) begin
          idleCntNxt = '0;
          if (src_last[grantId]) begin
            stateNxt    = IDLE;
            rrPtrNxt    = nextId;
            closedIdNxt = grantId;
          end
        end else begin
          // Parser backpressure counts toward the watchdog as well as source gaps.
          idleCntNxt = idleCnt + 1'b1;
          if (TIMEOUT != 0 && idleCnt == IDLE_LAST) stateNxt = FLUSH;
        end
      end
      FLUSH: begin
        dataIn_val  = 1'b1;
        dataIn_last = 1'b1;
        if (dataIn_ready) begin
          stateNxt      = IDLE;
          timeoutEvtNxt = 1'b1;
          rrPtrNxt      = nextId;
          closedIdNxt   = grantId;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rrPtr      <= '0;
      grantId    <= '0;
      closedId   <= '0;
      idleCnt    <= '0;
      timeoutEvt <= 1'b0;
    end else begin
      state      <= stateNxt;
      rrPtr      <= rrPtrNxt;
      grantId    <= grantIdNxt;
      closedId   <= closedIdNxt;
      idleCnt    <= idleCntNxt;
      timeoutEvt <= timeoutEvtNxt;
    end
  end

  // closedId is still the previous packet's owner when a drop pulse coincides with a closing beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_SRC; n++) lostCnt[n] <= '0;
    end else if (packetLost && lostCnt[closedId] != '1) begin
      lostCnt[closedId] <= lostCnt[closedId] + 1'b1;
    end
  end

  assign grant_id     = grantId;
  assign grant_active = (state != IDLE);
  assign timeout_evt  = timeoutEvt;

endmodule
